// File: rtl/fip_32_sqrt_iter.sv
// rtl/fip_32_sqrt_iter.sv - iterative restoring fixed-point square root, one result bit per clock
module fip_32_sqrt_iter #(
    parameter int FRA_BITS = 16
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_en,
    input  logic [31:0] i_rad,
    output logic [31:0] o_root,
    output logic        o_busy,
    output logic        o_valid
);
    localparam int ITER = (32 + FRA_BITS) / 2;
    localparam int OPW  = 32 + FRA_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [OPW-1:0]    op;
    logic [ITER+1:0]   rem;
    logic [ITER-1:0]   root;
    logic [4:0]        cnt;

    logic [ITER+1:0]   rem_sh;
    logic [ITER+1:0]   trial;
    logic [ITER+1:0]   rem_nxt;
    logic [ITER-1:0]   root_nxt;

    // Remainder never needs more than ITER+2 bits: before step i it is below 2^i.
    always_comb begin
        rem_sh   = (rem << 2) | {{ITER{1'b0}}, op[OPW-1 -: 2]};
        trial    = {root, 2'b01};
        rem_nxt  = rem_sh;
        root_nxt = {root[ITER-2:0], 1'b0};
        if (rem_sh >= trial) begin
            rem_nxt  = rem_sh - trial;
            root_nxt = {root[ITER-2:0], 1'b1};
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state   <= IDLE;
            op      <= '0;
            rem     <= '0;
            root    <= '0;
            cnt     <= '0;
            o_root  <= '0;
            o_busy  <= 1'b0;
            o_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    o_valid <= 1'b0;
                    if (i_en) begin
                        op     <= {i_rad, {FRA_BITS{1'b0}}};
                        rem    <= '0;
                        root   <= '0;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                        state  <= CALC;
                    end else begin
                        state  <= IDLE;
                    end
                end
                CALC: begin
                    op   <= op << 2;
                    rem  <= rem_nxt;
                    root <= root_nxt;
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'(ITER - 1)) begin
                        o_root  <= 32'(root_nxt);
                        o_valid <= 1'b1;
                        o_busy  <= 1'b0;
                        state   <= DONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_busy  <= 1'b0;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fip_32_sqrt_iter.sv
// tb/tb_fip_32_sqrt_iter.sv - scoreboard bench for fip_32_sqrt_iter with directed radicands
module tb_fip_32_sqrt_iter;
    localparam int LAT = 24;

    logic        i_clk;
    logic        i_rstn;
    logic        i_en;
    logic [31:0] i_rad;
    logic [31:0] o_root;
    logic        o_busy;
    logic        o_valid;

    typedef struct packed {
        logic [31:0] root;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_root = '0;
    logic        prev_valid = 1'b0;

    fip_32_sqrt_iter dut (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_en    (i_en),
        .i_rad   (i_rad),
        .o_root  (o_root),
        .o_busy  (o_busy),
        .o_valid (o_valid)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every o_valid and checks value, latency, width, hold.
    always @(negedge i_clk) begin
        if (!i_rstn) begin
            last_root  = '0;
            prev_valid = 1'b0;
        end else begin
            if (o_valid) begin
                if (prev_valid) check("valid_width", 32'd2, 32'd1);
                if (sb.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("root", o_root, e.root);
                    check("latency", 32'(cyc - e.acc), 32'(LAT));
                end
                last_root = o_root;
            end else if (o_root !== last_root) begin
                n_err++;
                $display("FAIL root_hold: got 0x%08h, expected 0x%08h", o_root, last_root);
            end
            prev_valid = o_valid;
        end
    end

    task automatic start(input logic [31:0] rad, input logic [31:0] exp_root);
        int t = 0;
        while (o_busy && t < 100) begin
            @(posedge i_clk); #1;
            t++;
        end
        if (o_busy) check("start_timeout", 32'd1, 32'd0);
        i_en  = 1'b1;
        i_rad = rad;
        @(posedge i_clk); #1;
        i_en  = 1'b0;
        i_rad = 32'hDEAD_BEEF;
        sb.push_back('{root: exp_root, acc: cyc});
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge i_clk); #1;
            t++;
        end
        if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge i_clk); #1;
    endtask

    logic [31:0] vec_rad[8] = '{32'h0004_0000, 32'h0002_0000, 32'h0001_0000, 32'hFFFF_FFFF,
                                32'h0000_0000, 32'h0019_0000, 32'h0000_0001, 32'h0000_4000};
    logic [31:0] vec_exp[8] = '{32'h0002_0000, 32'h0001_6A09, 32'h0001_0000, 32'h00FF_FFFF,
                                32'h0000_0000, 32'h0005_0000, 32'h0000_0100, 32'h0000_8000};

    initial begin
        int bc;
        int t;
        i_rstn = 1'b0;
        i_en   = 1'b0;
        i_rad  = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_root", o_root, 32'h0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        i_rstn = 1'b1;
        @(posedge i_clk); #1;

        for (int i = 0; i < 8; i++) begin
            start(vec_rad[i], vec_exp[i]);
            drain();
        end

        // Requests while busy are dropped; busy spans exactly LAT cycles.
        start(32'h0004_0000, 32'h0002_0000);
        bc = 1;
        for (int i = 0; i < 40; i++) begin
            i_en  = (i < 20);
            i_rad = 32'h0011_0000 * (i + 1);
            @(negedge i_clk);
            if (i > 0 && o_busy) bc++;
            @(posedge i_clk); #1;
        end
        i_en = 1'b0;
        check("busy_cycles", 32'(bc), 32'(LAT));
        drain();

        // Back-to-back start in the DONE cycle.
        start(32'h0019_0000, 32'h0005_0000);
        t = 0;
        while (!o_valid && t < 100) begin
            @(posedge i_clk); #1;
            t++;
        end
        if (!o_valid) check("b2b_timeout", 32'd1, 32'd0);
        i_en  = 1'b1;
        i_rad = 32'h0009_0000;
        @(posedge i_clk); #1;
        i_en  = 1'b0;
        sb.push_back('{root: 32'h0003_0000, acc: cyc});
        check("b2b_busy", 32'(o_busy), 32'd1);
        check("b2b_valid_drop", 32'(o_valid), 32'd0);
        drain();

        // Asynchronous reset mid-operation.
        start(32'hFFFF_FFFF, 32'h00FF_FFFF);
        repeat (9) @(posedge i_clk);
        #1;
        i_rstn = 1'b0;
        sb.delete();
        #1;
        check("arst_root", o_root, 32'h0);
        check("arst_busy", 32'(o_busy), 32'd0);
        check("arst_valid", 32'(o_valid), 32'd0);
        @(posedge i_clk); #1;
        i_rstn = 1'b1;
        repeat (30) @(posedge i_clk);
        #1;
        start(32'h0009_0000, 32'h0003_0000);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
